// File: rtl/min_hold_driver_pkg.sv
// rtl/min_hold_driver_pkg.sv - shared state encoding and width helpers for the min-hold output driver
package sync_pkg;

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        HOLD_HI = 2'd1,
        HIGH    = 2'd2,
        HOLD_LO = 2'd3
    } hold_state_t;

    localparam int unsigned DEF_PRESCALE      = 16;
    localparam int unsigned DEF_HOLD_HI_TICKS = 8;
    localparam int unsigned DEF_HOLD_LO_TICKS = 8;

    function automatic int unsigned presc_width(input int unsigned prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

    function automatic int unsigned tick_width(input int unsigned hi_ticks, input int unsigned lo_ticks);
        int unsigned m;
        m = (hi_ticks > lo_ticks) ? hi_ticks : lo_ticks;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/min_hold_driver_if.sv
// rtl/min_hold_driver_if.sv - level request in, conditioned pin and status out
interface min_hold_driver_if;
    logic indata;
    logic outdata;
    logic busy;
    logic dropped;

    modport master (output indata, input outdata, input busy, input dropped);
    modport slave  (input indata, output outdata, output busy, output dropped);
endinterface

// File: rtl/min_hold_driver_hold_timer.sv
// rtl/min_hold_driver_hold_timer.sv - prescaled down-counter; done marks the final cycle of a window
module hold_timer
    import sync_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE,
    parameter int unsigned TICK_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [TICK_W-1:0] ticks,
    output logic              done
);

    localparam int unsigned     PW        = presc_width(PRESCALE);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              run_q, run_d;

    // Window of ticks*PRESCALE cycles ends when both counters sit at zero.
    assign done = run_q && (presc_q == '0) && (tick_q == '0);

    always_comb begin
        presc_d = presc_q;
        tick_d  = tick_q;
        run_d   = run_q;
        if (load) begin
            presc_d = PRESC_MAX;
            tick_d  = ticks - 1'b1;
            run_d   = 1'b1;
        end else if (run_q) begin
            if (done) begin
                run_d = 1'b0;
            end else if (presc_q == '0) begin
                presc_d = PRESC_MAX;
                tick_d  = tick_q - 1'b1;
            end else begin
                presc_d = presc_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: rtl/min_hold_driver.sv
// rtl/min_hold_driver.sv - output conditioner enforcing minimum high/low times on a slow pin
module min_hold_driver
    import sync_pkg::*;
#(
    parameter int unsigned PRESCALE      = DEF_PRESCALE,
    parameter int unsigned HOLD_HI_TICKS = DEF_HOLD_HI_TICKS,
    parameter int unsigned HOLD_LO_TICKS = DEF_HOLD_LO_TICKS
) (
    input  logic              clk,
    input  logic              reset,
    min_hold_driver_if.slave  bus
);

    localparam int unsigned     TW   = tick_width(HOLD_HI_TICKS, HOLD_LO_TICKS);
    localparam logic [TW-1:0]   HI_T = TW'(HOLD_HI_TICKS);
    localparam logic [TW-1:0]   LO_T = TW'(HOLD_LO_TICKS);

    hold_state_t   state_q, state_d;
    logic          out_q, out_d;
    logic          busy_q, busy_d;
    logic          drop_q, drop_d;
    logic          pend_q, pend_d;
    logic          load;
    logic [TW-1:0] ticks;
    logic          done;

    hold_timer #(
        .PRESCALE (PRESCALE),
        .TICK_W   (TW)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .ticks (ticks),
        .done  (done)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        pend_d  = pend_q;
        drop_d  = 1'b0;
        load    = 1'b0;
        ticks   = HI_T;
        case (state_q)
            LOW: begin
                if (bus.indata) begin
                    out_d   = 1'b1;
                    state_d = HOLD_HI;
                    load    = 1'b1;
                    ticks   = HI_T;
                end
            end
            HIGH: begin
                if (!bus.indata) begin
                    out_d   = 1'b0;
                    state_d = HOLD_LO;
                    load    = 1'b1;
                    ticks   = LO_T;
                end
            end
            HOLD_HI: begin
                pend_d = pend_q | (bus.indata != out_q);
                if (done) begin
                    if (!bus.indata) begin
                        out_d   = 1'b0;
                        state_d = HOLD_LO;
                        load    = 1'b1;
                        ticks   = LO_T;
                    end else begin
                        state_d = HIGH;
                        drop_d  = pend_q;
                    end
                end
            end
            HOLD_LO: begin
                pend_d = pend_q | (bus.indata != out_q);
                if (done) begin
                    if (bus.indata) begin
                        out_d   = 1'b1;
                        state_d = HOLD_HI;
                        load    = 1'b1;
                        ticks   = HI_T;
                    end else begin
                        state_d = LOW;
                        drop_d  = pend_q;
                    end
                end
            end
            default: begin
                state_d = LOW;
                out_d   = 1'b0;
            end
        endcase
        // A new window never inherits requests seen in the previous one.
        if (load) begin
            pend_d = 1'b0;
        end
        busy_d = (state_d == HOLD_HI) || (state_d == HOLD_LO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOW;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.outdata = out_q;
    assign bus.busy    = busy_q;
    assign bus.dropped = drop_q;

endmodule
